// File: rtl/noc_tok_ocpl_init_bridge.sv
// Initiator-side token bridge: buffers AIC token writes, issues them as
// OCP-lite write commands, and runs the power-token idle handshake.
module noc_tok_ocpl_init_bridge #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tok_vld,
  input  logic [ADDR_W-1:0] i_tok_addr,
  input  logic [DATA_W-1:0] i_tok_data,
  output logic              o_tok_rdy,
  output logic [ADDR_W-1:0] o_ocpl_m_maddr,
  output logic [2:0]        o_ocpl_m_mcmd,
  output logic [DATA_W-1:0] o_ocpl_m_mdata,
  input  logic              i_ocpl_m_scmdaccept,
  input  logic              i_pwr_down_req,
  output logic              o_pwr_down_ack,
  output logic              o_pwr_tok_idle_req,
  input  logic              i_pwr_tok_idle_ack,
  input  logic              i_pwr_tok_idle_val,
  output logic              o_busy
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned EW = ADDR_W + DATA_W;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_REQ,
    ST_DOWN,
    ST_WAKE
  } state_t;

  state_t        state;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic [PW:0]   cnt_nxt;
  logic          mcmd_wr;
  logic          wr_nxt;
  logic          fifo_empty;
  logic          fifo_full;
  logic          stage_free;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          fifo_wr;

  assign fifo_empty = (cnt == '0);
  assign fifo_full  = (cnt == (PW+1)'(FIFO_DEPTH));
  assign o_tok_rdy  = (state == ST_RUN) & ~fifo_full & ~i_pwr_down_req;
  assign push       = i_tok_vld & o_tok_rdy;
  // The output stage can take a new token when empty or when its command is accepted.
  assign stage_free = ~mcmd_wr | i_ocpl_m_scmdaccept;
  assign pop        = stage_free & ~fifo_empty;
  // An empty FIFO lets the incoming token skip straight into the output stage.
  assign bypass     = stage_free & fifo_empty & push;
  assign fifo_wr    = push & ~bypass;

  assign o_ocpl_m_mcmd = {2'b00, mcmd_wr};

  // Next FIFO occupancy and output-stage occupancy, used for state and o_busy.
  always_comb begin
    cnt_nxt = cnt;
    case ({fifo_wr, pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
    wr_nxt = stage_free ? (~fifo_empty | push) : mcmd_wr;
  end

  // Token storage array, written at the tail pointer.
  always_ff @(posedge i_clk) begin
    if (fifo_wr) mem[wr_ptr] <= {i_tok_addr, i_tok_data};
  end

  // FIFO pointers, occupancy and the registered OCP-lite output stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      cnt            <= '0;
      mcmd_wr        <= 1'b0;
      o_ocpl_m_maddr <= '0;
      o_ocpl_m_mdata <= '0;
      o_busy         <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      cnt     <= cnt_nxt;
      mcmd_wr <= wr_nxt;
      if (pop) begin
        {o_ocpl_m_maddr, o_ocpl_m_mdata} <= mem[rd_ptr];
      end else if (bypass) begin
        o_ocpl_m_maddr <= i_tok_addr;
        o_ocpl_m_mdata <= i_tok_data;
      end
      o_busy <= (cnt_nxt != '0) | wr_nxt;
    end
  end

  // Power-token handshake FSM with registered IdleReq and power-down ack.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= ST_RUN;
      o_pwr_tok_idle_req <= 1'b0;
      o_pwr_down_ack     <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (i_pwr_down_req) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!i_pwr_down_req) begin
            state <= ST_RUN;
          end else if (fifo_empty && !mcmd_wr) begin
            state              <= ST_REQ;
            o_pwr_tok_idle_req <= 1'b1;
          end
        end
        // IdleReq is held until acknowledged even if the request is dropped.
        ST_REQ: begin
          if (i_pwr_tok_idle_ack && i_pwr_tok_idle_val) begin
            state          <= ST_DOWN;
            o_pwr_down_ack <= 1'b1;
          end
        end
        ST_DOWN: begin
          if (!i_pwr_down_req) begin
            state              <= ST_WAKE;
            o_pwr_tok_idle_req <= 1'b0;
            o_pwr_down_ack     <= 1'b0;
          end
        end
        ST_WAKE: begin
          if (!i_pwr_tok_idle_ack) state <= ST_RUN;
        end
        default: begin
          state              <= ST_RUN;
          o_pwr_tok_idle_req <= 1'b0;
          o_pwr_down_ack     <= 1'b0;
        end
      endcase
    end
  end

endmodule
